// File: rtl/timed_cmd_pkg.sv
// Shared types and helpers for the timestamped command scheduler.
// Holds the scheduler state encoding, the entry width helper and the modular late test.
package timed_cmd_pkg;

    localparam int unsigned MAX_TS_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } sched_state_t;

    // Width of one packed {ts, data} FIFO entry.
    function automatic int unsigned entry_width(input int unsigned ts_w, input int unsigned data_w);
        return ts_w + data_w;
    endfunction

    // A head is late when (head_ts - sample_idx) mod 2^ts_w has its top bit set.
    function automatic logic ts_is_late(input logic [MAX_TS_W-1:0] diff, input int unsigned ts_w);
        logic [MAX_TS_W-1:0] msb_down;
        msb_down = diff >> (ts_w - 1);
        return msb_down[0];
    endfunction

endpackage

// File: rtl/timed_cmd_fifo.sv
// Purpose: single-clock sync FIFO, first-word fall-through read, registered full/empty/level.
// Latency: a push is visible on pop_data and counted in level the cycle after it is accepted.
// Backpressure: pushes while full and pops while empty are ignored; flush clears everything.
module timed_cmd_fifo #(
    parameter int WIDTH = 88,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + LW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == LW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/timed_cmd_sched.sv
// Purpose: release queued (timestamp, command) pairs when sample_idx hits the head timestamp; TIMED_CMD_LATE_DROP_EN drops late heads.
// Latency: push N -> first compare N+3; match at M -> out_valid at M+1; releases at least 3 cycles apart.
// Backpressure: cmd_ready is a registered "level != DEPTH", where level counts the held head too.
module timed_cmd_sched
    import timed_cmd_pkg::*;
#(
    parameter int SAMPLE_CLK_WIDTH = 56,
    parameter int CMD_WIDTH        = 32,
    parameter int DEPTH            = 8
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [SAMPLE_CLK_WIDTH-1:0]   sample_idx,
    input  logic [SAMPLE_CLK_WIDTH-1:0]   cmd_ts,
    input  logic [CMD_WIDTH-1:0]          cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          flush,
    output logic [CMD_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    output logic                          late,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = int'(entry_width(SAMPLE_CLK_WIDTH, CMD_WIDTH));

    typedef struct packed {
        logic [SAMPLE_CLK_WIDTH-1:0] ts;
        logic [CMD_WIDTH-1:0]        data;
    } entry_t;

    sched_state_t                state;
    sched_state_t                state_nxt;
    entry_t                      push_entry;
    entry_t                      fifo_head;
    entry_t                      head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [LW-1:0]               fifo_level;
    logic [LW-1:0]               level_nxt;
    logic                        ready_q;
    logic                        push;
    logic                        pop;
    logic                        fire;
    logic                        miss;
    logic [SAMPLE_CLK_WIDTH-1:0] diff;
    logic [MAX_TS_W-1:0]         diff_ext;
    logic                        behind;
`ifndef TIMED_CMD_LATE_DROP_EN
    logic                        late_pend;
`endif

    assign push_entry = '{ts: cmd_ts, data: cmd_data};
    assign push       = cmd_valid && ready_q && !fifo_full && !flush;
    assign cmd_ready  = ready_q;
    assign diff       = head.ts - sample_idx;
    assign diff_ext   = MAX_TS_W'(diff);
    assign behind     = ts_is_late(diff_ext, SAMPLE_CLK_WIDTH);
    assign level      = fifo_level + LW'(state != IDLE);

    timed_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fire      = 1'b0;
        miss      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (diff == '0) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end else if (behind) begin
                    miss      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            pop       = 1'b0;
            fire      = 1'b0;
            miss      = 1'b0;
        end
    end

    always_comb begin
        level_nxt = level + LW'(push) - LW'(fire || miss);
        if (flush) begin
            level_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (level_nxt != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            head      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            late      <= 1'b0;
`ifndef TIMED_CMD_LATE_DROP_EN
            late_pend <= 1'b0;
`endif
        end else begin
            if (pop) begin
                head <= fifo_head;
            end
`ifdef TIMED_CMD_LATE_DROP_EN
            out_valid <= fire;
            late      <= miss;
            if (fire) begin
                out_data <= head.data;
            end
`else
            // A late head still executes; its late flag trails the strobe by one cycle.
            out_valid <= fire || miss;
            late_pend <= miss;
            late      <= late_pend;
            if (fire || miss) begin
                out_data <= head.data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_timed_cmd_sched.sv
// Self-checking bench for timed_cmd_sched: directed scenarios plus random traffic against a queue-based model.
module tb_timed_cmd_sched;

    localparam int W     = 56;
    localparam int CW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          aresetn;
    logic [W-1:0]  sample_idx;
    logic [W-1:0]  cmd_ts;
    logic [CW-1:0] cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          flush;
    logic [CW-1:0] out_data;
    logic          out_valid;
    logic          late;
    logic [LW-1:0] level;

    timed_cmd_sched #(
        .SAMPLE_CLK_WIDTH (W),
        .CMD_WIDTH        (CW),
        .DEPTH            (DEPTH)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .sample_idx (sample_idx),
        .cmd_ts     (cmd_ts),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .late       (late),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: the queue holds every accepted entry still owned by the scheduler (head first).
    typedef struct {
        logic [W-1:0]  ts;
        logic [CW-1:0] data;
        int            pc;
    } mentry_t;

    mentry_t       q[$];
    int            cyc        = 0;
    int            last_res   = -100;
    bit            rst_seen   = 0;
    bit            e_ov       = 0;
    bit            e_late     = 0;
    bit            e_chkdata  = 0;
    logic [CW-1:0] e_data     = '0;
    bit            pend_late  = 0;

    int ov_cnt = 0, late_cnt = 0;
    int last_ov_cyc = -1, last_late_cyc = -1;
    logic [CW-1:0] last_ov_data = '0;

    always @(negedge clk) begin
        bit            n_ov, n_late, n_chk;
        logic [CW-1:0] n_data;
        logic [W-1:0]  d;
        int            sz0, ev;
        if (rst_seen) begin
            chk("level", 64'(level), 64'(q.size()));
            chk("cmd_ready", 64'(cmd_ready), 64'(q.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("late", 64'(late), 64'(e_late));
            if (e_chkdata) chk("out_data", 64'(out_data), 64'(e_data));
            if (out_valid === 1'b1) begin
                ov_cnt++;
                last_ov_cyc  = cyc;
                last_ov_data = out_data;
            end
            if (late === 1'b1) begin
                late_cnt++;
                last_late_cyc = cyc;
            end
        end
        if (!aresetn) begin
            q.delete();
            e_ov      = 0;
            e_late    = 0;
            e_data    = '0;
            e_chkdata = 1;
            pend_late = 0;
            last_res  = cyc - 100;
            rst_seen  = 1;
        end else begin
            n_ov      = 0;
            n_late    = pend_late;
            pend_late = 0;
            n_chk     = 0;
            n_data    = '0;
            if (flush) begin
                q.delete();
                last_res = cyc;
            end else begin
                sz0 = q.size();
                if (sz0 > 0) begin
                    ev = (q[0].pc > last_res) ? q[0].pc + 3 : last_res + 3;
                    if (cyc >= ev) begin
                        d = q[0].ts - sample_idx;
                        if (d == '0) begin
                            n_ov = 1; n_chk = 1; n_data = q[0].data;
                            void'(q.pop_front());
                            last_res = cyc;
                        end else if (d[W-1]) begin
`ifdef TIMED_CMD_LATE_DROP_EN
                            n_late = 1;
`else
                            n_ov = 1; n_chk = 1; n_data = q[0].data;
                            pend_late = 1;
`endif
                            void'(q.pop_front());
                            last_res = cyc;
                        end
                    end
                end
                if (cmd_valid && sz0 != DEPTH) begin
                    q.push_back('{ts: cmd_ts, data: cmd_data, pc: cyc});
                end
            end
            e_ov      = n_ov;
            e_late    = n_late;
            e_chkdata = n_chk;
            e_data    = n_data;
        end
        cyc++;
    end

    // Stimulus: sample_idx advances by one every `rate` cycles (rate 0 freezes it).
    int           rate = 0;
    int           rcnt = 0;
    logic [W-1:0] mark_val = '0;
    int           mark_cyc = -1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rate != 0) begin
            rcnt++;
            if (rcnt >= rate) begin
                rcnt = 0;
                sample_idx = sample_idx + W'(1);
                if (sample_idx == mark_val && mark_cyc < 0) mark_cyc = cyc;
            end
        end
    endtask

    task automatic push(input logic [W-1:0] ts, input logic [CW-1:0] data);
        cmd_valid = 1'b1;
        cmd_ts    = ts;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int ov0, late0;

    initial begin
        aresetn    = 1'b0;
        sample_idx = '0;
        cmd_ts     = '0;
        cmd_data   = '0;
        cmd_valid  = 1'b0;
        flush      = 1'b0;
        run(3);
        aresetn = 1'b1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_late", 64'(late), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // Single command at ts=5, counter ticking every 100 clocks.
        rate = 100; rcnt = 0; mark_val = W'(5); mark_cyc = -1;
        ov0 = ov_cnt; late0 = late_cnt;
        push(W'(5), 32'hA5A5A5A5);
        while (sample_idx < W'(7)) tick();
        chk("t1_releases", 64'(ov_cnt - ov0), 64'd1);
        chk("t1_data", 64'(last_ov_data), 64'hA5A5A5A5);
        chk("t1_timing", 64'(last_ov_cyc), 64'(mark_cyc + 1));
        chk("t1_level", 64'(level), 64'd0);
        chk("t1_no_late", 64'(late_cnt - late0), 64'd0);

        // Three back-to-back commands.
        mark_val = W'(30); mark_cyc = -1;
        ov0 = ov_cnt; late0 = late_cnt;
        push(W'(10), 32'hB000_0010);
        push(W'(20), 32'hB000_0020);
        push(W'(30), 32'hB000_0030);
        while (sample_idx < W'(31)) tick();
        chk("t2_releases", 64'(ov_cnt - ov0), 64'd3);
        chk("t2_last_data", 64'(last_ov_data), 64'hB000_0030);
        chk("t2_last_timing", 64'(last_ov_cyc), 64'(mark_cyc + 1));
        chk("t2_no_late", 64'(late_cnt - late0), 64'd0);

        // Fill past capacity with far-future commands.
        rate = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cmd_ts   = sample_idx + W'(1000 + i);
            cmd_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        cmd_valid = 1'b0;
        chk("t3_level_full", 64'(level), 64'(DEPTH));
        chk("t3_ready_low", 64'(cmd_ready), 64'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t3_flush_level", 64'(level), 64'd0);
        chk("t3_flush_ready", 64'(cmd_ready), 64'd1);
        run(2);

        // Counter wrap through zero.
        sample_idx = 56'hFFFFFFFFFFFFFE; rate = 4; rcnt = 0;
        ov0 = ov_cnt; late0 = late_cnt;
        push(W'(1), 32'h1234_5678);
        run(30);
        chk("t4_releases", 64'(ov_cnt - ov0), 64'd1);
        chk("t4_data", 64'(last_ov_data), 64'h1234_5678);
        chk("t4_no_late", 64'(late_cnt - late0), 64'd0);

        // Counter reload jumps past the head timestamp.
        rate = 0; sample_idx = W'(10);
        ov0 = ov_cnt; late0 = late_cnt;
        push(W'(1000), 32'hDEAD_BEEF);
        run(6);
        sample_idx = 56'h2000;
        run(6);
        chk("t5_late", 64'(late_cnt - late0), 64'd1);
`ifdef TIMED_CMD_LATE_DROP_EN
        chk("t5_no_release", 64'(ov_cnt - ov0), 64'd0);
`else
        chk("t5_release", 64'(ov_cnt - ov0), 64'd1);
        chk("t5_data", 64'(last_ov_data), 64'hDEAD_BEEF);
        chk("t5_late_after", 64'(last_late_cyc), 64'(last_ov_cyc + 1));
`endif
        chk("t5_level", 64'(level), 64'd0);

        // Flush four future commands; a push in the flush cycle is dropped.
        sample_idx = W'(100);
        ov0 = ov_cnt; late0 = late_cnt;
        for (int i = 0; i < 4; i++) push(W'(200 + 10 * i), 32'hF000_0000 + 32'(i));
        chk("t6_level_pre", 64'(level), 64'd4);
        flush = 1'b1; cmd_valid = 1'b1; cmd_ts = W'(205); cmd_data = 32'hF0F0_F0F0;
        tick();
        flush = 1'b0; cmd_valid = 1'b0;
        chk("t6_level_post", 64'(level), 64'd0);
        rate = 1; rcnt = 0;
        run(150);
        chk("t6_no_release", 64'(ov_cnt - ov0), 64'd0);
        chk("t6_no_late", 64'(late_cnt - late0), 64'd0);

        // Random traffic, jumps, flushes and one mid-run reset.
        rate = 1 + int'($urandom_range(0, 2));
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                aresetn = 1'b0; run(2); aresetn = 1'b1;
            end
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_ts    = sample_idx + W'($urandom_range(0, 100)) - W'(20);
            cmd_data  = $urandom;
            flush     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 1) == 0) sample_idx = sample_idx + W'($urandom_range(0, 300));
                else sample_idx = sample_idx - W'($urandom_range(0, 300));
            end
            tick();
        end
        cmd_valid = 1'b0; flush = 1'b0;
        run(5);

        // Reset while commands are queued.
        rate = 0;
        for (int i = 0; i < 3; i++) push(sample_idx + W'(500 + i), 32'hE000_0000 + 32'(i));
        aresetn = 1'b0; run(2); aresetn = 1'b1;
        chk("t8_level", 64'(level), 64'd0);
        chk("t8_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t8_out_valid", 64'(out_valid), 64'd0);
        chk("t8_late", 64'(late), 64'd0);
        chk("t8_out_data", 64'(out_data), 64'd0);
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timed_cmd_sched.md
# timed_cmd_sched

Timestamped command scheduler that consumes the sample-clock counter's `sample_idx` bus and releases queued commands when the counter reaches each command's timestamp. Software or an upstream AXI-stream shim pushes (timestamp, command) pairs into a small FIFO. The head entry is compared against `sample_idx` every clock, and a one-cycle command strobe is emitted on match. It sits beside the sample clock in the radio datapath and drives timed retune, gain and TX/RX gating events.

## Interface
- `SAMPLE_CLK_WIDTH`, 56: width of `sample_idx` and timestamps.
- `CMD_WIDTH`, 32: command payload width.
- `DEPTH`, 8: FIFO entries; power of two, 2..64.

Ports:
- `clk`  in  1  single clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `sample_idx`  in  SAMPLE_CLK_WIDTH  current sample index from the sample clock.
- `cmd_ts`  in  SAMPLE_CLK_WIDTH  target timestamp of the pushed command.
- `cmd_data`  in  CMD_WIDTH  pushed command payload.
- `cmd_valid`  in  1  push request.
- `cmd_ready`  out  1  FIFO not full; a push occurs when `cmd_valid && cmd_ready`.
- `flush`  in  1  discard all queued and held commands.
- `out_data`  out  CMD_WIDTH  released command payload.
- `out_valid`  out  1  one-cycle release strobe.
- `late`  out  1  one-cycle strobe: head timestamp already passed.
- `level`  out  $clog2(DEPTH)+1  entries queued, including the held head.

## Operation
- Sync FIFO of `{ts, data}` entries. States: IDLE, LOAD, WAIT.
- **IDLE**:
  - Stay while the FIFO is empty.
  - On non-empty, pop and go to LOAD. The head register is written at the end of that cycle.
- **LOAD**: one cycle; go to WAIT.
- **WAIT**: each cycle compute `diff = (head_ts - sample_idx) mod 2^SAMPLE_CLK_WIDTH`.
  - `diff == 0` (on time): register release. `out_data <= head_data`, `out_valid <= 1`. Then go to IDLE.
  - `diff[MSB] == 1` (late): handled per Configuration. Then go to IDLE.
  - Otherwise stay in WAIT.
- Wrap-around: the modular compare treats timestamps up to 2^(W-1)-1 ahead as future and everything else as past. Counter wrap through 0 is therefore correct.
- `sample_idx` jumps (counter reload) are handled naturally. A jump past the head timestamp produces a late event, never a silent hang.
- Only the head is evaluated; commands release strictly in push order. An out-of-order later entry is evaluated only after its predecessor leaves.
- `flush`:
  - Empties the FIFO and returns the FSM to IDLE the next cycle.
  - Suppresses any release that would be registered in the same cycle.
  - A push in the flush cycle is dropped.
- Simultaneous push and pop in the same cycle are both honoured; `level` is unchanged.
- Reset mid-operation:
  - All queued and held entries are lost.
  - `out_valid=0`, `late=0`, `out_data=0`, `level=0`, `cmd_ready=1`, state IDLE.

## Timing
- Push at cycle N: FIFO non-empty at N+1; popped into the head in IDLE at N+1; LOAD at N+2; first compare at N+3.
- Match seen at cycle M (combinational `sample_idx == head_ts`): `out_valid` high in cycle M+1 for exactly one cycle.
- Minimum spacing between back-to-back releases: 3 cycles (WAIT→IDLE→LOAD→WAIT).
- `cmd_ready` is registered-full based. It deasserts when `level == DEPTH`.
- `late` and `out_valid` are never both high in the same cycle.

## Configuration
- Macro `TIMED_CMD_LATE_DROP_EN`.
- **Defined**: a late head is discarded. `late` pulses for one cycle and `out_valid` stays low.
- **Undefined**: a late head is executed anyway. `out_valid` and `late` are NOT both asserted; instead `out_valid` pulses with `out_data = head_data`, and `late` pulses on the following cycle.

## Structure
- `timed_cmd_pkg` holds:
  - state enum `sched_state_t` (IDLE, LOAD, WAIT);
  - parameterized-width entry struct helper;
  - function `ts_is_late(diff)` returning the MSB test.
- Sub-module `timed_cmd_fifo`: single-clock sync FIFO with registered full/empty and level; no other sub-modules.

## Test plan
- Reset `sample_idx=0`, incrementing by 1 every 100 clocks. Push ts=5, data=32'hA5A5A5A5. Expect one `out_valid` with `out_data=A5A5A5A5` exactly one clock after `sample_idx` becomes 5, and `level` returns to 0.
- Push ts=10, 20, 30 back-to-back. Expect three single-cycle releases, in order, at the cycles after `sample_idx` = 10, 20, 30. `late` is never asserted.
- Push DEPTH+2 entries with ts far ahead. Expect `cmd_ready` low after DEPTH accepted, the extra pushes ignored, and `level=DEPTH`.
- `sample_idx` near `56'hFFFFFFFFFFFFFE`; push ts=1. Expect release after the counter wraps to 1, and no late event.
- Queue ts=1000, then jump `sample_idx` from 10 to 56'h2000 (reload).
  - With `TIMED_CMD_LATE_DROP_EN`: expect a `late` pulse only.
  - Without it: expect `out_valid` followed by `late`.
- Queue 4 future entries, assert `flush` one cycle. Expect `level=0` next cycle and no releases when those timestamps pass.
